// File: rtl/usb_ft_packet_tx_pkg.sv
// Shared framing constants and types for the FT245 upstream packet transmitter.
package usb_ft_packet_tx_pkg;

    localparam logic [7:0]  HDR_SYMBOL = 8'h55;
    localparam int unsigned HDR_LEN    = 12;
    localparam logic [7:0]  TRL_SYMBOL = 8'hAA;
    localparam int unsigned TRL_LEN    = 8;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} ft_tx_state_t;
    typedef enum logic [1:0] {WAIT_TXE, WR_HI, WR_LO} ft_byte_state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } usb_word_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Wire order of an entry: addr low, addr high, data low, data high.
    function automatic logic [7:0] payload_byte(input usb_word_t w, input logic [1:0] idx);
        logic [7:0] b;
        b = w.addr[7:0];
        case (idx)
            2'd1:    b = w.addr[15:8];
            2'd2:    b = w.data[7:0];
            2'd3:    b = w.data[15:8];
            default: b = w.addr[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/usb_tx_word_fifo.sv
// Synchronous show-ahead FIFO of addr/data entries with level and full/empty flags.
module usb_tx_word_fifo
    import usb_ft_packet_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  usb_word_t                wdata,
    input  logic                     pop,
    output usb_word_t                rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    usb_word_t          mem_q [DEPTH];
    logic [AW-1:0]      wptr_q, rptr_q;
    logic [AW:0]        level_q;
    logic               do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/usb_ft_packet_tx.sv
// Frames buffered addr/data entries as header+payload+trailer and writes them to the FT245.
module usb_ft_packet_tx
    import usb_ft_packet_tx_pkg::*;
#(
    parameter logic [7:0]  HEADER_KEY_SYMBOL         = HDR_SYMBOL,
    parameter int unsigned HEADER_KEY_SYMBOL_NUMBER  = HDR_LEN,
    parameter logic [7:0]  TRAILER_KEY_SYMBOL        = TRL_SYMBOL,
    parameter int unsigned TRAILER_KEY_SYMBOL_NUMBER = TRL_LEN,
    parameter int unsigned PKT_WORDS                 = 2,
    parameter int unsigned FIFO_DEPTH                = 16,
    parameter int unsigned WR_HIGH_CYCLES            = 4,
    parameter int unsigned WR_LOW_CYCLES             = 2,
    parameter int unsigned TXE_TIMEOUT               = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          word_valid,
    output logic                          word_ready,
    input  logic [15:0]                   word_addr,
    input  logic [15:0]                   word_data,
    input  logic                          flush,
    input  logic                          rx_busy,
    input  logic                          FT_TXEn,
    output logic                          FT_WR,
    output logic [7:0]                    FT_DATA_Out,
    output logic                          FT_DATA_OE,
    output logic                          tx_busy,
    output logic                          pkt_sent,
    output logic                          timeout_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = $clog2(max3(HEADER_KEY_SYMBOL_NUMBER,
                                             TRAILER_KEY_SYMBOL_NUMBER, 4 * PKT_WORDS) + 1);
    localparam int unsigned TW = $clog2(TXE_TIMEOUT + 1);
    localparam int unsigned NW = $clog2(PKT_WORDS + 1);
    localparam int unsigned PW = $clog2(max3(WR_HIGH_CYCLES, WR_LOW_CYCLES, 1) + 1);

    ft_tx_state_t   state_q;
    ft_byte_state_t bstate_q;
    logic [BW-1:0]  byte_cnt_q;
    logic [PW-1:0]  phase_q;
    logic [TW-1:0]  tmo_q;
    logic [NW-1:0]  n_q, left_q, disc_q;
    logic           flush_pend_q, txe_meta_q, txe_s_q;

    usb_word_t      head;
    logic [LW-1:0]  level;
    logic           full, empty, fifo_pop, byte_done, start, tmo_hit;
    logic [BW-1:0]  last_idx;
    logic [7:0]     cur_byte;
    logic [NW-1:0]  start_n;

    usb_tx_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (word_valid),
        .wdata ({word_addr, word_data}),
        .pop   (fifo_pop),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign word_ready = ~full;
    assign fifo_level = level;

    always_comb begin
        last_idx = '0;
        cur_byte = '0;
        case (state_q)
            HEADER: begin
                last_idx = BW'(HEADER_KEY_SYMBOL_NUMBER - 1);
                cur_byte = HEADER_KEY_SYMBOL;
            end
            PAYLOAD: begin
                last_idx = BW'({n_q - NW'(1), 2'b11});
                cur_byte = payload_byte(head, byte_cnt_q[1:0]);
            end
            TRAILER: begin
                last_idx = BW'(TRAILER_KEY_SYMBOL_NUMBER - 1);
                cur_byte = TRAILER_KEY_SYMBOL;
            end
            default: ;
        endcase
    end

    assign byte_done = (bstate_q == WR_LO) && (phase_q == PW'(WR_LOW_CYCLES - 1));
    assign tmo_hit   = (tmo_q == TW'(TXE_TIMEOUT - 1));
    assign start     = (state_q == IDLE) && !rx_busy && (disc_q == '0) &&
                       ((level >= LW'(PKT_WORDS)) || (flush_pend_q && !empty));
    assign start_n   = (level >= LW'(PKT_WORDS)) ? NW'(PKT_WORDS) : NW'(level);
    // Entries leave the FIFO as their last byte completes, or one per cycle while
    // draining what an aborted packet had latched.
    assign fifo_pop  = ((state_q == PAYLOAD) && byte_done && (byte_cnt_q[1:0] == 2'b11)) ||
                       ((state_q == IDLE) && (disc_q != '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bstate_q     <= WAIT_TXE;
            byte_cnt_q   <= '0;
            phase_q      <= '0;
            tmo_q        <= '0;
            n_q          <= '0;
            left_q       <= '0;
            disc_q       <= '0;
            flush_pend_q <= 1'b0;
            txe_meta_q   <= 1'b1;
            txe_s_q      <= 1'b1;
            FT_WR        <= 1'b0;
            FT_DATA_Out  <= '0;
            FT_DATA_OE   <= 1'b0;
            tx_busy      <= 1'b0;
            pkt_sent     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            txe_meta_q  <= FT_TXEn;
            txe_s_q     <= txe_meta_q;
            pkt_sent    <= 1'b0;
            timeout_err <= 1'b0;
            if (flush)      flush_pend_q <= 1'b1;
            else if (start) flush_pend_q <= 1'b0;

            if (state_q == IDLE) begin
                if (fifo_pop) disc_q <= disc_q - 1'b1;
                if (start) begin
                    state_q    <= HEADER;
                    bstate_q   <= WAIT_TXE;
                    byte_cnt_q <= '0;
                    phase_q    <= '0;
                    tmo_q      <= '0;
                    n_q        <= start_n;
                    left_q     <= start_n;
                    FT_DATA_OE <= 1'b1;
                    tx_busy    <= 1'b1;
                end
            end else begin
                unique case (bstate_q)
                    WAIT_TXE: begin
                        FT_DATA_Out <= cur_byte;
                        if (!txe_s_q) begin
                            bstate_q <= WR_HI;
                            FT_WR    <= 1'b1;
                            phase_q  <= '0;
                            tmo_q    <= '0;
                        end else if (tmo_hit) begin
                            state_q     <= IDLE;
                            FT_DATA_OE  <= 1'b0;
                            tx_busy     <= 1'b0;
                            timeout_err <= 1'b1;
                            tmo_q       <= '0;
                            disc_q      <= left_q;
                            left_q      <= '0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    WR_HI: begin
                        if (phase_q == PW'(WR_HIGH_CYCLES - 1)) begin
                            bstate_q <= WR_LO;
                            FT_WR    <= 1'b0;
                            phase_q  <= '0;
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end
                    WR_LO: begin
                        if (byte_done) begin
                            bstate_q <= WAIT_TXE;
                            phase_q  <= '0;
                            if (fifo_pop) left_q <= left_q - 1'b1;
                            if (byte_cnt_q == last_idx) begin
                                byte_cnt_q <= '0;
                                case (state_q)
                                    HEADER:  state_q <= PAYLOAD;
                                    PAYLOAD: state_q <= TRAILER;
                                    default: begin
                                        state_q    <= IDLE;
                                        pkt_sent   <= 1'b1;
                                        FT_DATA_OE <= 1'b0;
                                        tx_busy    <= 1'b0;
                                    end
                                endcase
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                            end
                        end else begin
                            phase_q <= phase_q + 1'b1;
                        end
                    end
                    default: bstate_q <= WAIT_TXE;
                endcase
            end
        end
    end

endmodule
